// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared types and Booth recode function for the radix-4 multiplier
package booth4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } booth_digit_t;

    // Window is {q1, q0, q-1}; digit value is (-2*q1 + q0 + q-1)
    function automatic booth_digit_t booth_recode(input logic [2:0] win);
        booth_digit_t d;
        d.zero = (win == 3'b000) || (win == 3'b111);
        d.neg  = win[2] && !d.zero;
        d.two  = (win == 3'b011) || (win == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth4_recoder.sv
// rtl/booth4_recoder.sv - combinational radix-4 Booth digit recoder
module booth4_recoder
    import booth4_pkg::*;
(
    input  logic [2:0] i_window,
    output logic       o_zero,
    output logic       o_neg,
    output logic       o_two
);

    booth_digit_t w_digit;

    assign w_digit = booth_recode(i_window);
    assign o_zero  = w_digit.zero;
    assign o_neg   = w_digit.neg;
    assign o_two   = w_digit.two;

endmodule

// File: rtl/booth4_mult_unit.sv
// rtl/booth4_mult_unit.sv - iterative radix-4 Booth multiplier, signed/unsigned, start/valid handshake
module booth4_mult_unit
    import booth4_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_multiplicand,
    input  logic [WIDTH-1:0] i_multiplier,
    output logic             o_busy,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_overflow
);

    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [E+1:0]    r_a;
    logic [E+1:0]    r_m;
    logic [E-1:0]    r_q;
    logic            r_qm1;
    logic            r_signed;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic            r_ovf;

    logic            w_load;
    logic            w_iter;
    logic            w_finish;
    logic            w_busy;
    logic            w_zero;
    logic            w_neg;
    logic            w_two;
    logic [E+1:0]    w_m_ext;
    logic [E-1:0]    w_q_ext;
    logic [E+1:0]    w_mag;
    logic [E+1:0]    w_addend;
    logic [E+1:0]    w_sum;
    logic [E+1:0]    w_a_nxt;
    logic [E-1:0]    w_q_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic            w_ovf_nxt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = i_start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != ST_IDLE);
        w_load   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_iter   = (r_state == ST_RUN);
        w_finish = w_iter && (r_cnt == LAST);
    end

    // Both modes share the signed datapath; unsigned operands just get zero extension
    assign w_m_ext = {{4{i_is_signed & i_multiplicand[WIDTH-1]}}, i_multiplicand};
    assign w_q_ext = {{2{i_is_signed & i_multiplier[WIDTH-1]}}, i_multiplier};

    booth4_recoder u_recoder (
        .i_window ({r_q[1:0], r_qm1}),
        .o_zero   (w_zero),
        .o_neg    (w_neg),
        .o_two    (w_two)
    );

    always_comb begin
        w_mag    = w_two ? {r_m[E:0], 1'b0} : r_m;
        w_addend = w_zero ? '0 : (w_neg ? ~w_mag : w_mag);
        w_sum    = r_a + w_addend + {{(E+1){1'b0}}, (w_neg & ~w_zero)};
        w_a_nxt  = {{2{w_sum[E+1]}}, w_sum[E+1:2]};
        w_q_nxt  = {w_sum[1:0], r_q[E-1:2]};
        w_lo_nxt = w_q_nxt[WIDTH-1:0];
        w_hi_nxt = {w_a_nxt[WIDTH-3:0], w_q_nxt[WIDTH+1:WIDTH]};
        if (r_signed) begin
            w_ovf_nxt = (w_hi_nxt != {WIDTH{w_lo_nxt[WIDTH-1]}});
        end else begin
            w_ovf_nxt = (w_hi_nxt != '0);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a      <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a      <= '0;
            r_m      <= w_m_ext;
            r_q      <= w_q_ext;
            r_qm1    <= 1'b0;
            r_signed <= i_is_signed;
            r_cnt    <= '0;
        end else if (w_iter) begin
            r_a      <= w_a_nxt;
            r_q      <= w_q_nxt;
            r_qm1    <= r_q[1];
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Results capture the final iteration directly so they are ready one cycle before valid
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_DONE);
            if (w_finish) begin
                r_lo  <= w_lo_nxt;
                r_hi  <= w_hi_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign o_busy         = w_busy;
    assign o_result_valid = r_valid;
    assign o_result_lo    = r_lo;
    assign o_result_hi    = r_hi;
    assign o_overflow     = r_ovf;

endmodule

// File: tb/tb_booth4_mult_unit.sv
// tb/tb_booth4_mult_unit.sv - directed self-checking bench for booth4_mult_unit (WIDTH 32 and 8)
module tb_booth4_mult_unit;

    logic        clk;
    logic        rst_n;

    logic        start32, signed32;
    logic [31:0] m32, q32, lo32, hi32;
    logic        busy32, v32, ovf32;

    logic        start8, signed8;
    logic [7:0]  m8, q8, lo8, hi8;
    logic        busy8, v8, ovf8;

    int n_cmp;
    int n_fail;
    int edges;
    int nv;
    int first;

    booth4_mult_unit #(.WIDTH(32)) dut32 (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start32),
        .i_is_signed    (signed32),
        .i_multiplicand (m32),
        .i_multiplier   (q32),
        .o_busy         (busy32),
        .o_result_valid (v32),
        .o_result_lo    (lo32),
        .o_result_hi    (hi32),
        .o_overflow     (ovf32)
    );

    booth4_mult_unit #(.WIDTH(8)) dut8 (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start8),
        .i_is_signed    (signed8),
        .i_multiplicand (m8),
        .i_multiplier   (q8),
        .o_busy         (busy8),
        .o_result_valid (v8),
        .o_result_lo    (lo8),
        .o_result_hi    (hi8),
        .o_overflow     (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a posedge; returns edges from acceptance to result_valid
    task automatic go32(input logic s, input logic [31:0] m, input logic [31:0] q, output int e);
        signed32 = s;
        m32      = m;
        q32      = q;
        start32  = 1'b1;
        @(posedge clk); #1;
        start32  = 1'b0;
        m32      = $urandom;
        q32      = $urandom;
        signed32 = ~s;
        e = 0;
        while (v32 !== 1'b1 && e < 40) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        start32 = 1'b0; signed32 = 1'b0; m32 = '0; q32 = '0;
        start8  = 1'b0; signed8  = 1'b0; m8  = '0; q8  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {63'd0, busy32}, 64'd0);
        check("rst_valid", {63'd0, v32},    64'd0);
        check("rst_prod",  {hi32, lo32},    64'd0);
        check("rst_ovf",   {63'd0, ovf32},  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        go32(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, edges);
        check("s_m3x5_lat",  edges, 18);
        check("s_m3x5_prod", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("s_m3x5_ovf",  {63'd0, ovf32}, 64'd0);
        check("s_m3x5_busy", {63'd0, busy32}, 64'd0);

        go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges);
        check("u_max_prod", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        check("u_max_ovf",  {63'd0, ovf32}, 64'd1);

        go32(1'b0, 32'h8000_0000, 32'h0000_0001, edges);
        check("u_msb_prod", {hi32, lo32}, 64'h0000_0000_8000_0000);
        check("u_msb_ovf",  {63'd0, ovf32}, 64'd0);

        go32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        check("s_minxm1_prod", {hi32, lo32}, 64'h0000_0000_8000_0000);
        check("s_minxm1_ovf",  {63'd0, ovf32}, 64'd1);

        go32(1'b1, 32'h8000_0000, 32'h8000_0000, edges);
        check("s_minsq_prod", {hi32, lo32}, 64'h4000_0000_0000_0000);
        check("s_minsq_ovf",  {63'd0, ovf32}, 64'd1);

        // WIDTH=8: ignored start mid-run, operand changes after acceptance
        signed8 = 1'b0; m8 = 8'hFF; q8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; m8 = 8'h12; q8 = 8'h34; signed8 = 1'b1;
        nv = 0; first = 0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 2) begin
                start8 = 1'b1;
                m8 = 8'h03;
            end
            @(posedge clk); #1;
            if (e == 2) start8 = 1'b0;
            if (e == 3) check("w8_busy_mid", {63'd0, busy8}, 64'd1);
            if (v8 === 1'b1) begin
                nv++;
                if (first == 0) first = e;
            end
        end
        check("w8_lat",     first, 6);
        check("w8_nvalid",  nv, 1);
        check("w8_prod",    {48'd0, hi8, lo8}, 64'h0000_0000_0000_FE01);
        check("w8_ovf",     {63'd0, ovf8}, 64'd1);

        // Back-to-back: second start issued in the result_valid cycle
        go32(1'b0, 32'h0000_0007, 32'h0000_0006, edges);
        check("b2b_first_prod", {hi32, lo32}, 64'h0000_0000_0000_002A);
        go32(1'b1, 32'h1234_5678, 32'hFFFF_FFFE, edges);
        check("b2b_second_lat",  edges, 18);
        check("b2b_second_prod", {hi32, lo32}, 64'hFFFF_FFFF_DB97_5310);
        check("b2b_second_ovf",  {63'd0, ovf32}, 64'd0);

        // Abort at iteration 7
        signed32 = 1'b0; m32 = 32'h0000_0123; q32 = 32'h0000_0456; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  {63'd0, busy32}, 64'd0);
        check("abort_valid", {63'd0, v32},    64'd0);
        check("abort_prod",  {hi32, lo32},    64'd0);
        check("abort_ovf",   {63'd0, ovf32},  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (v32 === 1'b1) nv++;
        end
        check("abort_no_valid", nv, 0);

        go32(1'b0, 32'h0001_0000, 32'h0001_0000, edges);
        check("post_rst_lat",  edges, 18);
        check("post_rst_prod", {hi32, lo32}, 64'h0000_0001_0000_0000);
        check("post_rst_ovf",  {63'd0, ovf32}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
